// File: rtl/mcast_credit_tracker_if.sv
// -----------------------------------------------------------------------------
// mcast_credit_tracker_if
// Bundles the credit-return bus, the head-flit consume handshake and the
// status outputs of mcast_credit_tracker.
//   upd_valid/upd_vc/upd_amt : per-destination credit returns (slice d)
//   cons_valid/cons_vc/cons_amt/cons_ready : consume handshake
//   credit_cnt/min_dst       : released credit and bottleneck node per VC
//   err_ovf/err_vc           : sticky error flags
// modport slave  : the tracker
// modport master : the sender / credit-return side
// -----------------------------------------------------------------------------
interface mcast_credit_tracker_if #(
    parameter int NUM_DST = 16,
    parameter int NUM_VC  = 2,
    parameter int VC_W    = 1,
    parameter int UPD_W   = 8,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = (NUM_DST > 1) ? $clog2(NUM_DST) : 1
);
    logic [NUM_DST-1:0]       upd_valid;
    logic [NUM_DST*VC_W-1:0]  upd_vc;
    logic [NUM_DST*UPD_W-1:0] upd_amt;
    logic                     cons_valid;
    logic [VC_W-1:0]          cons_vc;
    logic [CNT_W-1:0]         cons_amt;
    logic                     cons_ready;
    logic [NUM_VC*CNT_W-1:0]  credit_cnt;
    logic [NUM_VC*IDX_W-1:0]  min_dst;
    logic                     err_ovf;
    logic                     err_vc;

    modport master (
        output upd_valid, upd_vc, upd_amt, cons_valid, cons_vc, cons_amt,
        input  cons_ready, credit_cnt, min_dst, err_ovf, err_vc
    );

    modport slave (
        input  upd_valid, upd_vc, upd_amt, cons_valid, cons_vc, cons_amt,
        output cons_ready, credit_cnt, min_dst, err_ovf, err_vc
    );
endinterface

// File: rtl/mcast_credit_tracker.sv
// -----------------------------------------------------------------------------
// mcast_credit_tracker
// Per-VC credit tracker for a multicast source port. Each VC keeps one
// accumulator per destination; the credit every masked destination has
// returned (the minimum accumulator) is released into that VC's counter,
// which the sender consumes through a valid/ready handshake.
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : mcast_credit_tracker_if.slave (returns, consume handshake, status)
// -----------------------------------------------------------------------------
module mcast_credit_tracker #(
    parameter int                  NUM_DST     = 16,
    parameter logic [NUM_DST-1:0]  DST_MASK    = {NUM_DST{1'b0}},
    parameter int                  NUM_VC      = 2,
    parameter int                  VC_W        = 1,
    parameter int                  UPD_W       = 8,
    parameter int                  ACC_W       = 16,
    parameter int                  CNT_W       = 32,
    parameter logic [CNT_W-1:0]    INIT_CREDIT = CNT_W'(64),
    parameter bit                  IS_FC       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rstn,
    mcast_credit_tracker_if.slave   bus
);
    localparam int IDX_W = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;
    // Accumulator sums are formed wide enough to hold any acc + amount
    // without wrapping, so saturation is a plain compare.
    localparam int SUM_W = ((ACC_W > UPD_W) ? ACC_W : UPD_W) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_W{1'b1}});
    // One extra bit so "vc >= NUM_VC" is a real compare even when
    // NUM_VC == 2**VC_W.
    localparam logic [VC_W:0] VC_LIM = (VC_W+1)'(NUM_VC);

    generate
        if (IS_FC && (DST_MASK == '0)) begin : g_chk_mask
            $error("mcast_credit_tracker: IS_FC=1 requires a non-empty DST_MASK");
        end
        if ((2 ** VC_W) < NUM_VC) begin : g_chk_vcw
            $error("mcast_credit_tracker: VC_W too narrow for NUM_VC");
        end
        if (ACC_W > CNT_W) begin : g_chk_accw
            $error("mcast_credit_tracker: ACC_W must not exceed CNT_W");
        end
    endgenerate

    genvar gi;

    logic [NUM_DST-1:0][VC_W-1:0]  upd_vc_d;
    logic [NUM_DST-1:0][UPD_W-1:0] upd_amt_d;
    logic [NUM_DST-1:0]            bad_upd;
    logic [NUM_VC-1:0][CNT_W-1:0]  cnt_q;
    logic [NUM_VC-1:0]             ovf_ev;
    logic [CNT_W-1:0]              cnt_sel;
    logic                          cons_vc_ok;
    logic                          ready_fc;
    logic                          fire;
    logic                          err_ovf_reg;
    logic                          err_vc_reg;

    // Unpack per-destination return slices and flag out-of-range VCs.
    for (gi = 0; gi < NUM_DST; gi++) begin : g_dst
        assign upd_vc_d[gi]  = bus.upd_vc[gi*VC_W +: VC_W];
        assign upd_amt_d[gi] = bus.upd_amt[gi*UPD_W +: UPD_W];
        assign bad_upd[gi]   = bus.upd_valid[gi] && ({1'b0, upd_vc_d[gi]} >= VC_LIM);
    end

    // Ready looks only at registered counters, so a return in the same
    // cycle can never enable a consume.
    always_comb begin
        cnt_sel = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (bus.cons_vc == VC_W'(v)) begin
                cnt_sel = cnt_q[v];
            end
        end
    end

    assign cons_vc_ok     = ({1'b0, bus.cons_vc} < VC_LIM);
    assign ready_fc       = cons_vc_ok && (cnt_sel >= bus.cons_amt);
    assign fire           = bus.cons_valid && ready_fc;
    assign bus.cons_ready = IS_FC ? ready_fc : 1'b1;

    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
        logic [ACC_W-1:0]   acc_reg [NUM_DST];
        logic [CNT_W-1:0]   cnt_reg;
        logic [IDX_W-1:0]   min_reg;
        logic [SUM_W-1:0]   a_sum   [NUM_DST];
        logic [ACC_W-1:0]   a_next  [NUM_DST];
        logic [NUM_DST-1:0] acc_sat;
        logic [ACC_W-1:0]   m;
        logic [IDX_W-1:0]   m_idx;
        logic               found;
        logic               fire_v;
        logic [CNT_W:0]     cnt_sum;
        logic [CNT_W-1:0]   cnt_next;

        // Add this cycle's returns, saturate, and find the lowest-index
        // minimum over the masked destinations. Unmasked accumulators stay 0
        // and are excluded from the minimum.
        always_comb begin
            acc_sat = '0;
            m       = '0;
            m_idx   = '0;
            found   = 1'b0;
            for (int d = 0; d < NUM_DST; d++) begin
                a_sum[d] = SUM_W'(acc_reg[d]);
                if (DST_MASK[d] && bus.upd_valid[d] && (upd_vc_d[d] == VC_W'(gi))) begin
                    a_sum[d] = a_sum[d] + SUM_W'(upd_amt_d[d]);
                end
                if (a_sum[d] > ACC_MAX) begin
                    a_next[d]  = '1;
                    acc_sat[d] = 1'b1;
                end else begin
                    a_next[d] = a_sum[d][ACC_W-1:0];
                end
                if (DST_MASK[d] && (!found || (a_next[d] < m))) begin
                    m     = a_next[d];
                    m_idx = IDX_W'(d);
                    found = 1'b1;
                end
            end
        end

        assign fire_v   = fire && (bus.cons_vc == VC_W'(gi));
        // The ready rule guarantees cons_amt <= cnt_reg, so the only
        // out-of-range result is an overflow into bit CNT_W.
        assign cnt_sum  = {1'b0, cnt_reg} + (CNT_W+1)'(m)
                        - (fire_v ? {1'b0, bus.cons_amt} : '0);
        assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        assign ovf_ev[gi] = (|acc_sat) || cnt_sum[CNT_W];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt_reg <= INIT_CREDIT;
                min_reg <= '0;
                for (int d = 0; d < NUM_DST; d++) begin
                    acc_reg[d] <= '0;
                end
            end else if (IS_FC) begin
                cnt_reg <= cnt_next;
                min_reg <= m_idx;
                // Subtracting m (0 when nothing is releasable) moves the
                // common credit out of every masked accumulator.
                for (int d = 0; d < NUM_DST; d++) begin
                    acc_reg[d] <= DST_MASK[d] ? (a_next[d] - m) : '0;
                end
            end
        end

        assign cnt_q[gi] = cnt_reg;
        assign bus.credit_cnt[gi*CNT_W +: CNT_W] = IS_FC ? cnt_reg : '1;
        assign bus.min_dst[gi*IDX_W +: IDX_W]    = min_reg;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_ovf_reg <= 1'b0;
            err_vc_reg  <= 1'b0;
        end else if (IS_FC) begin
            if (|ovf_ev) begin
                err_ovf_reg <= 1'b1;
            end
            if ((bus.cons_valid && !cons_vc_ok) || (|bad_upd)) begin
                err_vc_reg <= 1'b1;
            end
        end
    end

    assign bus.err_ovf = err_ovf_reg;
    assign bus.err_vc  = err_vc_reg;
endmodule

// File: tb/tb_mcast_credit_tracker.sv
// -----------------------------------------------------------------------------
// tb_mcast_credit_tracker
// Three instances: a main FC build (4 nodes, mask 1011, 3 VCs so VC 3 is out
// of range), a narrow build (ACC_W=4, CNT_W=8) for saturation, and a non-FC
// build. Expected register values are queued when stimulus is driven and
// compared once the clock edge has produced them.
// -----------------------------------------------------------------------------
module tb_mcast_credit_tracker;
    localparam int            ND   = 4;
    localparam logic [ND-1:0] MASK = 4'b1011;

    // observation selectors
    localparam int M_CNT0 = 0,  M_CNT1 = 1,  M_CNT2 = 2,  M_MIN0 = 3,  M_MIN1 = 4;
    localparam int M_OVF  = 5,  M_VERR = 6,  M_ACC0 = 7,  M_ACC1 = 8,  M_ACC3 = 9;
    localparam int S_CNT0 = 10, S_CNT1 = 11, S_OVF  = 12, S_ACC0 = 13;
    localparam int N_CNT0 = 14, N_CNT1 = 15, N_OVF  = 16, N_MIN  = 17;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mcast_credit_tracker_if #(.NUM_DST(ND), .NUM_VC(3), .VC_W(2), .UPD_W(8), .CNT_W(32)) bus_m ();
    mcast_credit_tracker_if #(.NUM_DST(ND), .NUM_VC(2), .VC_W(1), .UPD_W(8), .CNT_W(8))  bus_s ();
    mcast_credit_tracker_if #(.NUM_DST(ND), .NUM_VC(2), .VC_W(1), .UPD_W(8), .CNT_W(32)) bus_n ();

    mcast_credit_tracker #(.NUM_DST(ND), .DST_MASK(MASK), .NUM_VC(3), .VC_W(2), .UPD_W(8),
        .ACC_W(16), .CNT_W(32), .INIT_CREDIT(32'd64), .IS_FC(1'b1))
        dut_m (.clk(clk), .rstn(rstn), .bus(bus_m));

    mcast_credit_tracker #(.NUM_DST(ND), .DST_MASK(MASK), .NUM_VC(2), .VC_W(1), .UPD_W(8),
        .ACC_W(4), .CNT_W(8), .INIT_CREDIT(8'd250), .IS_FC(1'b1))
        dut_s (.clk(clk), .rstn(rstn), .bus(bus_s));

    mcast_credit_tracker #(.NUM_DST(ND), .DST_MASK(MASK), .NUM_VC(2), .VC_W(1), .UPD_W(8),
        .ACC_W(16), .CNT_W(32), .INIT_CREDIT(32'd64), .IS_FC(1'b0))
        dut_n (.clk(clk), .rstn(rstn), .bus(bus_n));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            M_CNT0:  return 64'(bus_m.credit_cnt[31:0]);
            M_CNT1:  return 64'(bus_m.credit_cnt[63:32]);
            M_CNT2:  return 64'(bus_m.credit_cnt[95:64]);
            M_MIN0:  return 64'(bus_m.min_dst[1:0]);
            M_MIN1:  return 64'(bus_m.min_dst[3:2]);
            M_OVF:   return 64'(bus_m.err_ovf);
            M_VERR:  return 64'(bus_m.err_vc);
            M_ACC0:  return 64'(dut_m.g_vc[0].acc_reg[0]);
            M_ACC1:  return 64'(dut_m.g_vc[0].acc_reg[1]);
            M_ACC3:  return 64'(dut_m.g_vc[0].acc_reg[3]);
            S_CNT0:  return 64'(bus_s.credit_cnt[7:0]);
            S_CNT1:  return 64'(bus_s.credit_cnt[15:8]);
            S_OVF:   return 64'(bus_s.err_ovf);
            S_ACC0:  return 64'(dut_s.g_vc[0].acc_reg[0]);
            N_CNT0:  return 64'(bus_n.credit_cnt[31:0]);
            N_CNT1:  return 64'(bus_n.credit_cnt[63:32]);
            N_OVF:   return 64'(bus_n.err_ovf);
            N_MIN:   return 64'(bus_n.min_dst);
            default: return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic idle_all();
        bus_m.upd_valid = '0; bus_m.upd_vc = '0; bus_m.upd_amt = '0;
        bus_m.cons_valid = 1'b0; bus_m.cons_vc = '0; bus_m.cons_amt = '0;
        bus_s.upd_valid = '0; bus_s.upd_vc = '0; bus_s.upd_amt = '0;
        bus_s.cons_valid = 1'b0; bus_s.cons_vc = '0; bus_s.cons_amt = '0;
        bus_n.upd_valid = '0; bus_n.upd_vc = '0; bus_n.upd_amt = '0;
        bus_n.cons_valid = 1'b0; bus_n.cons_vc = '0; bus_n.cons_amt = '0;
    endtask

    // One transaction: the edge applies the driven inputs, then queued
    // expectations are compared and the inputs return to idle.
    task automatic tick(input string name);
        @(posedge clk);
        #1;
        $display("[%0t] txn %s", $time, name);
        drain();
        idle_all();
    endtask

    task automatic ret_m(input int vc, input int d, input int amt);
        bus_m.upd_valid[d]       = 1'b1;
        bus_m.upd_vc[d*2 +: 2]   = 2'(vc);
        bus_m.upd_amt[d*8 +: 8]  = 8'(amt);
    endtask

    task automatic ret_s(input int vc, input int d, input int amt);
        bus_s.upd_valid[d]       = 1'b1;
        bus_s.upd_vc[d]          = 1'(vc);
        bus_s.upd_amt[d*8 +: 8]  = 8'(amt);
    endtask

    task automatic cons_m(input int vc, input int amt);
        bus_m.cons_valid = 1'b1;
        bus_m.cons_vc    = 2'(vc);
        bus_m.cons_amt   = 32'(amt);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset state
        expect_val("rst_cnt0", M_CNT0, 64);
        expect_val("rst_cnt1", M_CNT1, 64);
        expect_val("rst_cnt2", M_CNT2, 64);
        expect_val("rst_min0", M_MIN0, 0);
        expect_val("rst_ovf",  M_OVF,  0);
        expect_val("rst_verr", M_VERR, 0);
        expect_val("rst_s_cnt0", S_CNT0, 250);
        expect_val("rst_n_cnt0", N_CNT0, 64'hFFFF_FFFF);
        drain();
        rstn = 1'b1;
        bus_m.cons_vc = 2'd0; bus_m.cons_amt = 32'd14;
        #1 check_eq("rst_ready", 64'(bus_m.cons_ready), 1);

        // VC0 returns 5/3/7 -> release 3
        ret_m(0, 0, 5); ret_m(0, 1, 3); ret_m(0, 3, 7);
        expect_val("r1_cnt0", M_CNT0, 67);
        expect_val("r1_cnt1", M_CNT1, 64);
        expect_val("r1_min0", M_MIN0, 1);
        expect_val("r1_acc0", M_ACC0, 2);
        expect_val("r1_acc1", M_ACC1, 0);
        expect_val("r1_acc3", M_ACC3, 4);
        tick("vc0 returns 5/3/7");

        ret_m(0, 1, 3);
        expect_val("r2_cnt0", M_CNT0, 69);
        expect_val("r2_min0", M_MIN0, 0);
        expect_val("r2_acc0", M_ACC0, 0);
        expect_val("r2_acc1", M_ACC1, 1);
        expect_val("r2_acc3", M_ACC3, 2);
        tick("vc0 dst1 returns 3");

        // unmasked destination
        ret_m(0, 2, 9);
        expect_val("unm_cnt0", M_CNT0, 69);
        expect_val("unm_ovf",  M_OVF,  0);
        expect_val("unm_verr", M_VERR, 0);
        expect_val("unm_acc1", M_ACC1, 1);
        tick("unmasked dst2 returns 9");

        // consume down to 20 then 6
        cons_m(0, 49);
        #1 check_eq("c49_ready", 64'(bus_m.cons_ready), 1);
        expect_val("c49_cnt0", M_CNT0, 20);
        tick("consume 49");

        cons_m(0, 14);
        #1 check_eq("c14_ready", 64'(bus_m.cons_ready), 1);
        expect_val("c14_cnt0", M_CNT0, 6);
        tick("consume 14");

        // blocked request while VC1 receives a full return
        cons_m(0, 14);
        ret_m(1, 0, 10); ret_m(1, 1, 10); ret_m(1, 3, 10);
        #1 check_eq("blk_ready", 64'(bus_m.cons_ready), 0);
        expect_val("blk_cnt0", M_CNT0, 6);
        expect_val("blk_cnt1", M_CNT1, 74);
        expect_val("blk_min1", M_MIN1, 0);
        tick("blocked consume + vc1 return 10");

        // refill VC0 to 20
        ret_m(0, 0, 14); ret_m(0, 1, 14); ret_m(0, 3, 14);
        expect_val("ref_cnt0", M_CNT0, 20);
        tick("vc0 return 14");

        // simultaneous consume 14 and release 8
        cons_m(0, 14);
        ret_m(0, 0, 8); ret_m(0, 1, 8); ret_m(0, 3, 8);
        #1 check_eq("sim_ready", 64'(bus_m.cons_ready), 1);
        expect_val("sim_cnt0", M_CNT0, 14);
        expect_val("sim_acc1", M_ACC1, 1);
        expect_val("sim_acc3", M_ACC3, 2);
        tick("consume 14 + release 8");

        // consume exactly the whole balance, then one more is refused
        cons_m(0, 14);
        #1 check_eq("ex_ready", 64'(bus_m.cons_ready), 1);
        expect_val("ex_cnt0", M_CNT0, 0);
        tick("consume exact balance");

        cons_m(0, 1);
        #1 check_eq("zero_ready", 64'(bus_m.cons_ready), 0);
        expect_val("zero_cnt0", M_CNT0, 0);
        tick("consume from empty");

        // out-of-range VC
        cons_m(3, 0);
        #1 check_eq("badvc_ready", 64'(bus_m.cons_ready), 0);
        expect_val("badvc_verr", M_VERR, 1);
        expect_val("badvc_ovf",  M_OVF,  0);
        tick("consume on vc3");

        ret_m(3, 0, 5);
        expect_val("badret_acc0", M_ACC0, 0);
        expect_val("badret_cnt0", M_CNT0, 0);
        expect_val("badret_verr", M_VERR, 1);
        tick("return on vc3");

        // narrow build: accumulator saturation
        ret_s(0, 0, 15); ret_s(0, 1, 0);
        expect_val("s1_acc0", S_ACC0, 15);
        expect_val("s1_ovf",  S_OVF,  0);
        expect_val("s1_cnt0", S_CNT0, 250);
        tick("narrow dst0 returns 15");

        ret_s(0, 0, 3); ret_s(0, 1, 0);
        expect_val("s2_acc0", S_ACC0, 15);
        expect_val("s2_ovf",  S_OVF,  1);
        expect_val("s2_cnt0", S_CNT0, 250);
        tick("narrow dst0 returns 3 (saturate)");

        // asynchronous reset mid-stream
        ret_m(1, 0, 5);
        #2 rstn = 1'b0;
        #1;
        expect_val("ar_cnt0", M_CNT0, 64);
        expect_val("ar_cnt1", M_CNT1, 64);
        expect_val("ar_verr", M_VERR, 0);
        expect_val("ar_min1", M_MIN1, 0);
        expect_val("ar_acc1", M_ACC1, 0);
        expect_val("ar_s_acc0", S_ACC0, 0);
        expect_val("ar_s_ovf",  S_OVF,  0);
        drain();
        $display("[%0t] txn async reset", $time);
        idle_all();
        @(posedge clk);
        #1 rstn = 1'b1;

        // narrow build: counter saturation
        ret_s(1, 0, 10); ret_s(1, 1, 10); ret_s(1, 3, 10);
        expect_val("cs_cnt1", S_CNT1, 255);
        expect_val("cs_ovf",  S_OVF,  1);
        tick("narrow vc1 return 10 (counter saturate)");

        // non-FC build
        bus_n.upd_valid[0] = 1'b1; bus_n.upd_amt[7:0] = 8'd7;
        bus_n.cons_valid = 1'b1; bus_n.cons_vc = 1'b0; bus_n.cons_amt = 32'hFFFF_FFFF;
        #1 check_eq("nfc_ready", 64'(bus_n.cons_ready), 1);
        expect_val("nfc_cnt0", N_CNT0, 64'hFFFF_FFFF);
        expect_val("nfc_cnt1", N_CNT1, 64'hFFFF_FFFF);
        expect_val("nfc_ovf",  N_OVF,  0);
        expect_val("nfc_min",  N_MIN,  0);
        tick("non-fc return + consume");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mcast_credit_tracker.md
Name: mcast_credit_tracker

Overview:
Per-virtual-channel credit tracker for a multicast (FC) source port. It collects credit returns from every destination node in a configurable destination mask and releases to the sender only the credit that all masked destinations have returned. It gates head-flit injection with a valid/ready handshake and reports the bottleneck destination per VC. It is the parametrised, multi-VC successor of the single-channel cast credit counter: synthesizable, saturating, with error flags.

Parameters:
NUM_DST, 16, number of destination nodes (NOC_WIDTH*NOC_HEIGHT); node index = y*NOC_WIDTH+x
DST_MASK, {NUM_DST{1'b0}}, bit d=1 means destination d must return credit
NUM_VC, 2, number of independent credit channels
VC_W, 1, width of VC index; must satisfy 2**VC_W >= NUM_VC
UPD_W, 8, width of one credit-return amount
ACC_W, 16, width of each per-destination accumulator
CNT_W, 32, width of each released credit counter
INIT_CREDIT, 64, reset value of every VC counter (CAST_CREDIT_ALLOC)
IS_FC, 1, 0 = not an FC start port; block reports unlimited credit

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
upd_valid  in  NUM_DST  credit return from destination d is valid this cycle
upd_vc  in  NUM_DST*VC_W  VC of each return, slice d
upd_amt  in  NUM_DST*UPD_W  credit amount of each return, slice d
cons_valid  in  1  sender requests to pop a head flit
cons_vc  in  VC_W  VC of the request
cons_amt  in  CNT_W  credit to consume (packet length minus 2)
cons_ready  out  1  request may proceed
credit_cnt  out  NUM_VC*CNT_W  released credit per VC
min_dst  out  NUM_VC*$clog2(NUM_DST)  bottleneck destination index per VC
err_ovf  out  1  sticky: an accumulator or counter saturated
err_vc  out  1  sticky: cons_vc or upd_vc >= NUM_VC while valid

Behaviour:
- Reset (rstn=0, asynchronous): credit_cnt[v]=INIT_CREDIT; acc[v][d]=0; min_dst=0; err_ovf=0; err_vc=0. A reset asserted mid-operation discards all accumulated credit.
- IS_FC=0: credit_cnt = all ones, cons_ready=1, acc held at 0, errors held at 0, min_dst=0.
- IS_FC=1 with DST_MASK==0 is illegal and raises an elaboration-time $error.
- Step 1 (combinational, per VC v): a_next[v][d] = acc[v][d] + (upd_valid[d] && upd_vc[d]==v && DST_MASK[d] ? upd_amt[d] : 0). Returns from unmasked destinations are ignored. The sum saturates at 2**ACC_W-1; saturation sets err_ovf.
- Step 2: m[v] = min of a_next[v][d] over masked d. Ties resolve to the lowest index. The index of the minimum is registered into min_dst[v] every cycle.
- Step 3: if m[v]>0, acc[v][d] <= a_next[v][d]-m[v] for masked d, and m[v] is added to credit_cnt[v]. Otherwise acc[v][d] <= a_next[v][d].
- Consume: fire = cons_valid && cons_ready. cons_ready = (cons_vc<NUM_VC) && (credit_cnt[cons_vc] >= cons_amt). It is combinational from registered state only; same-cycle returns do not raise it.
- Counter update: credit_cnt[v] <= credit_cnt[v] + m[v] - (fire && cons_vc==v ? cons_amt : 0). Compute at CNT_W+1 bits, then saturate at 2**CNT_W-1 and set err_ovf. Underflow cannot occur because of the ready rule.
- Latency: a return visible in credit_cnt the cycle after upd_valid; a consume visible the cycle after fire. A simultaneous return and consume on the same VC apply both in one cycle.
- Out-of-range VC: cons_ready=0 and err_vc is set when cons_valid. Returns with bad upd_vc are dropped and set err_vc.
- Errors clear only on reset.

Test Plan:
1. Reset, NUM_DST=4, DST_MASK=4'b1011, INIT_CREDIT=64 -> credit_cnt[0]=credit_cnt[1]=64, cons_ready=1 for cons_amt=14, errors 0.
2. VC0 returns: dst0=5, dst1=3, dst3=7 in the same cycle -> next cycle credit_cnt[0]=67, acc={2,0,-,4}, min_dst[0]=1. A later dst1=3 return -> credit_cnt[0]=69, acc={0,1,-,2}, min_dst[0]=0.
3. Return from dst2 (unmasked) of 9 -> credit_cnt unchanged, no flag.
4. Consume: cnt=20, cons_amt=14, fire -> cnt=6. Next request with cons_amt=14 sees cons_ready=0; cnt stays 6. Same-cycle full return of 10 on VC1 -> only VC1 changes.
5. Simultaneous: VC0 fire cons_amt=14 with a full return m=8, cnt=20 -> cnt=14.
6. ACC_W=4: dst0 returns 15 then 3 while dst1 returns 0 -> acc[0][0]=15 and err_ovf=1. Assert rstn low mid-stream -> all state back to reset values; IS_FC=0 build -> credit_cnt all ones and cons_ready=1 always.
